// File: rtl/icache_pkg.sv
// Shared types and geometry for the L1 instruction-cache refill path.
package icache_pkg;

  localparam int unsigned IC_SETS  = 64;
  localparam int unsigned IC_WORDS = 4;
  localparam int unsigned IC_SET_W = $clog2(IC_SETS);
  localparam int unsigned IC_OFF_W = $clog2(IC_WORDS);
  localparam int unsigned IC_TAG_W = 32 - IC_SET_W - IC_OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    FILL = 2'b10,
    DONE = 2'b11
  } refill_state_t;

  // Tag width left over after set index, word offset and byte offset.
  function automatic int unsigned tag_width(input int unsigned sets, input int unsigned words);
    return 32 - $clog2(sets) - $clog2(words) - 2;
  endfunction

endpackage

// File: rtl/refill_beat_counter.sv
// Loadable modulo-N counter; last_o flags the final count (N-1).
module refill_beat_counter #(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] r_cnt;

  // N is a power of two, so the increment wraps naturally.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (inc_i) begin
      r_cnt <= W'(r_cnt + W'(1));
    end
  end

  assign cnt_o  = r_cnt;
  assign last_o = (r_cnt == W'(N - 1));

endmodule

// File: rtl/icache_refill_ctlr.sv
// L1 I-cache miss refill engine: burst-reads a block and streams it into the data array.
// Optional ICACHE_CRITICAL_WORD_FIRST_EN starts the burst at the missing word and wraps.
module icache_refill_ctlr
  import icache_pkg::*;
#(
  parameter  int unsigned S               = IC_SETS,
  parameter  int unsigned WORDS_PER_BLOCK = IC_WORDS,
  localparam int unsigned SET_W           = $clog2(S),
  localparam int unsigned OFF_W           = $clog2(WORDS_PER_BLOCK),
  localparam int unsigned TAG_W           = tag_width(S, WORDS_PER_BLOCK)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [31:0]      pc_f_i,
  input  logic             instr_hit_f_i,
  input  logic             ic_repl_permit_i,
  output logic             mem_req_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_ack_i,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             fill_we_o,
  output logic [SET_W-1:0] fill_set_o,
  output logic [OFF_W-1:0] fill_word_o,
  output logic [31:0]      fill_data_o,
  output logic [TAG_W-1:0] fill_tag_o,
  output logic             fill_done_o,
  output logic             refill_busy_o
);

  refill_state_t    r_state;
  logic [TAG_W-1:0] r_blk_tag;
  logic [SET_W-1:0] r_blk_set;
  logic [OFF_W-1:0] r_blk_off;
  logic             r_mem_req;
  logic [31:0]      r_mem_addr;
  logic             r_done;
  logic             r_busy;

  logic [OFF_W-1:0] w_start_off;
  logic [31:0]      w_miss_addr;
  logic [OFF_W-1:0] w_beat_cnt;
  logic             w_last;
  logic             w_beat;
  logic             w_load;
  logic             w_miss;
  logic [1:0]       w_unused_pc_lsb;

  assign w_unused_pc_lsb = pc_f_i[1:0];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign w_start_off = r_blk_off;
  assign w_miss_addr = {pc_f_i[31:2], 2'b00};
`else
  assign w_start_off = '0;
  assign w_miss_addr = {pc_f_i[31:OFF_W+2], (OFF_W+2)'(0)};
`endif

  assign w_miss = ~instr_hit_f_i & ic_repl_permit_i;
  assign w_load = (r_state == REQ) & mem_ack_i;
  // Beats are accepted only in FILL; a beat racing a reset is dropped.
  assign w_beat = (r_state == FILL) & mem_rvalid_i & ~reset_i;

  refill_beat_counter #(
    .N (WORDS_PER_BLOCK)
  ) u_beat_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (w_load),
    .load_val_i ('0),
    .inc_i      (w_beat),
    .cnt_o      (w_beat_cnt),
    .last_o     (w_last)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_blk_tag  <= '0;
      r_blk_set  <= '0;
      r_blk_off  <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_blk_tag  <= pc_f_i[31 -: TAG_W];
            r_blk_set  <= pc_f_i[OFF_W+2 +: SET_W];
            r_blk_off  <= pc_f_i[2 +: OFF_W];
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_miss_addr;
            r_busy     <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_state   <= FILL;
          end
        end
        FILL: begin
          if (w_beat && w_last) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req_o     = r_mem_req;
  assign mem_addr_o    = r_mem_addr;
  assign fill_we_o     = w_beat;
  assign fill_data_o   = w_beat ? mem_rdata_i : '0;
  assign fill_set_o    = r_blk_set;
  assign fill_tag_o    = r_blk_tag;
  assign fill_word_o   = (r_state == IDLE) ? r_blk_off : OFF_W'(w_start_off + w_beat_cnt);
  assign fill_done_o   = r_done;
  assign refill_busy_o = r_busy;

endmodule

// File: tb/tb_icache_refill_ctlr.sv
// Directed bench for icache_refill_ctlr; expectations follow ICACHE_CRITICAL_WORD_FIRST_EN.
module tb_icache_refill_ctlr;

  localparam int unsigned S   = 64;
  localparam int unsigned WPB = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] pc_f_i;
  logic        instr_hit_f_i;
  logic        ic_repl_permit_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        fill_we_o;
  logic [5:0]  fill_set_o;
  logic [1:0]  fill_word_o;
  logic [31:0] fill_data_o;
  logic [21:0] fill_tag_o;
  logic        fill_done_o;
  logic        refill_busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  icache_refill_ctlr #(.S(S), .WORDS_PER_BLOCK(WPB)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .pc_f_i           (pc_f_i),
    .instr_hit_f_i    (instr_hit_f_i),
    .ic_repl_permit_i (ic_repl_permit_i),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_ack_i        (mem_ack_i),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
    .fill_we_o        (fill_we_o),
    .fill_set_o       (fill_set_o),
    .fill_word_o      (fill_word_o),
    .fill_data_o      (fill_data_o),
    .fill_tag_o       (fill_tag_o),
    .fill_done_o      (fill_done_o),
    .refill_busy_o    (refill_busy_o)
  );

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam logic [31:0] ADDR_1234 = 32'h0000_1234;
  localparam logic [31:0] ADDR_2048 = 32'h0000_2048;
  localparam int          OFF_1234  = 1;
  localparam int          OFF_2048  = 2;
`else
  localparam logic [31:0] ADDR_1234 = 32'h0000_1230;
  localparam logic [31:0] ADDR_2048 = 32'h0000_2040;
  localparam int          OFF_1234  = 0;
  localparam int          OFF_2048  = 0;
`endif

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({mem_req_o, refill_busy_o, fill_done_o, fill_we_o} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_strobes cyc%0d: got req/busy/done/we=%b%b%b%b want 0000",
                 c, mem_req_o, refill_busy_o, fill_done_o, fill_we_o);
      end
      n_checks++;
      if ({mem_addr_o, fill_set_o, fill_tag_o, fill_word_o, fill_data_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_data cyc%0d: addr=%h set=%h tag=%h word=%0d data=%h want all 0",
                 c, mem_addr_o, fill_set_o, fill_tag_o, fill_word_o, fill_data_o);
      end
    end
    @(negedge clk); reset_i = 1'b0; instr_hit_f_i = 1'b1; #1;
    n_checks++;
    if (mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_req: got %b want 0", mem_req_o);
    end
    @(negedge clk); #1;
    n_checks++;
    if (refill_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_hit_idle_busy: got %b want 0", refill_busy_o);
    end
  endtask

  task automatic test_basic_miss();
    logic [1:0] w;
    @(negedge clk); pc_f_i = 32'h0000_1234; instr_hit_f_i = 1'b0; ic_repl_permit_i = 1'b1; #1;
    n_checks++;
    if (mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_req_miss_cycle: got %b want 0", mem_req_o);
    end
    @(negedge clk); instr_hit_f_i = 1'b1; #1;
    n_checks++;
    if ({mem_req_o, refill_busy_o} !== 2'b11 || mem_addr_o !== ADDR_1234) begin
      n_fail++;
      $display("FAIL basic_req: got req=%b busy=%b addr=%h want 1 1 %h",
               mem_req_o, refill_busy_o, mem_addr_o, ADDR_1234);
    end
    @(negedge clk); #1;
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== ADDR_1234) begin
      n_fail++; $display("FAIL basic_req_hold: got req=%b addr=%h want 1 %h", mem_req_o, mem_addr_o, ADDR_1234);
    end
    @(negedge clk); mem_ack_i = 1'b1; #1;
    n_checks++;
    if (mem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL basic_req_at_ack: got %b want 1", mem_req_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ack_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hD000_0000 + i; #1;
      w = 2'((OFF_1234 + i) % 4);
      n_checks++;
      if (mem_req_o !== 1'b0 || fill_we_o !== 1'b1 || fill_word_o !== w ||
          fill_data_o !== 32'hD000_0000 + i || fill_set_o !== 6'h23) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got req=%b we=%b word=%0d data=%h set=%h want 0 1 %0d %h 23",
                 i, mem_req_o, fill_we_o, fill_word_o, fill_data_o, fill_set_o, w, 32'hD000_0000 + i);
      end
    end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_checks++;
    if (fill_done_o !== 1'b1 || fill_tag_o !== 22'h4 || fill_set_o !== 6'h23 ||
        fill_we_o !== 1'b0 || refill_busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done: got done=%b tag=%h set=%h we=%b busy=%b want 1 4 23 0 1",
               fill_done_o, fill_tag_o, fill_set_o, fill_we_o, refill_busy_o);
    end
    @(negedge clk); #1;
    n_checks++;
    if (fill_done_o !== 1'b0 || refill_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_one_shot: got done=%b busy=%b want 0 0", fill_done_o, refill_busy_o);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] pat;
    int writes;
    logic [1:0] w;
    pat = 8'b1010_0101;  // bit 0 first
    writes = 0;
    @(negedge clk); pc_f_i = 32'h0000_2048; instr_hit_f_i = 1'b0; ic_repl_permit_i = 1'b1; #1;
    @(negedge clk); instr_hit_f_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_0001; #1;
    n_checks++;
    if (fill_we_o !== 1'b0 || mem_addr_o !== ADDR_2048) begin
      n_fail++; $display("FAIL gap_spurious_req: got we=%b addr=%h want 0 %h", fill_we_o, mem_addr_o, ADDR_2048);
    end
    @(negedge clk); mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_0002; #1;
    n_checks++;
    if (fill_we_o !== 1'b0) begin
      n_fail++; $display("FAIL gap_beat_with_ack: got we=%b want 0", fill_we_o);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); mem_ack_i = 1'b0; mem_rvalid_i = pat[c]; mem_rdata_i = 32'hA500_0000 + writes; #1;
      if (fill_we_o === 1'b1) begin
        w = 2'((OFF_2048 + writes) % 4);
        n_checks++;
        if (fill_word_o !== w || fill_set_o !== 6'h04 || fill_data_o !== 32'hA500_0000 + writes) begin
          n_fail++;
          $display("FAIL gap_write%0d: got word=%0d set=%h data=%h want %0d 04 %h",
                   writes, fill_word_o, fill_set_o, fill_data_o, w, 32'hA500_0000 + writes);
        end
        writes++;
      end
    end
    n_checks++;
    if (writes != 4) begin
      n_fail++; $display("FAIL gap_write_count: got %0d want 4", writes);
    end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_checks++;
    if (fill_done_o !== 1'b1 || fill_tag_o !== 22'h8) begin
      n_fail++; $display("FAIL gap_done: got done=%b tag=%h want 1 8", fill_done_o, fill_tag_o);
    end
    @(negedge clk); mem_rvalid_i = 1'b1; #1;
    n_checks++;
    if (fill_we_o !== 1'b0 || refill_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL gap_idle_rvalid: got we=%b busy=%b want 0 0", fill_we_o, refill_busy_o);
    end
    @(negedge clk); mem_rvalid_i = 1'b0;
  endtask

  task automatic test_permit();
    @(negedge clk); pc_f_i = 32'h0000_1234; instr_hit_f_i = 1'b0; ic_repl_permit_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (mem_req_o !== 1'b0 || refill_busy_o !== 1'b0) begin
        n_fail++; $display("FAIL permit_low_cyc%0d: got req=%b busy=%b want 0 0", c, mem_req_o, refill_busy_o);
      end
    end
    ic_repl_permit_i = 1'b1;
    @(negedge clk); instr_hit_f_i = 1'b1; mem_ack_i = 1'b1; #1;
    n_checks++;
    if (mem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL permit_req: got %b want 1", mem_req_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ack_i = 1'b0; ic_repl_permit_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7700_0000 + i; #1;
      n_checks++;
      if (fill_we_o !== 1'b1 || refill_busy_o !== 1'b1) begin
        n_fail++; $display("FAIL permit_drop_beat%0d: got we=%b busy=%b want 1 1", i, fill_we_o, refill_busy_o);
      end
    end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_checks++;
    if (fill_done_o !== 1'b1 || refill_busy_o !== 1'b1) begin
      n_fail++; $display("FAIL permit_drop_done: got done=%b busy=%b want 1 1", fill_done_o, refill_busy_o);
    end
    @(negedge clk); #1;
    n_checks++;
    if (refill_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL permit_drop_busy_end: got %b want 0", refill_busy_o);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); pc_f_i = 32'h0000_1234; instr_hit_f_i = 1'b0; ic_repl_permit_i = 1'b1;
    @(negedge clk); mem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ack_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1100_0000 + i;
    end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_checks++;
    if (fill_done_o !== 1'b1 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done_ignores_miss: got done=%b req=%b want 1 0", fill_done_o, mem_req_o);
    end
    @(negedge clk); #1;
    n_checks++;
    if (mem_req_o !== 1'b0 || refill_busy_o !== 1'b0 || fill_done_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got req=%b busy=%b done=%b want 0 0 0", mem_req_o, refill_busy_o, fill_done_o);
    end
    @(negedge clk); instr_hit_f_i = 1'b1; mem_ack_i = 1'b1; #1;
    n_checks++;
    if (mem_req_o !== 1'b1 || refill_busy_o !== 1'b1 || mem_addr_o !== ADDR_1234) begin
      n_fail++; $display("FAIL b2b_rereq: got req=%b busy=%b addr=%h want 1 1 %h",
                         mem_req_o, refill_busy_o, mem_addr_o, ADDR_1234);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ack_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2200_0000 + i;
    end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_checks++;
    if (fill_done_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_done: got %b want 1", fill_done_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk); pc_f_i = 32'h0000_1234; instr_hit_f_i = 1'b0; ic_repl_permit_i = 1'b1;
    @(negedge clk); instr_hit_f_i = 1'b1; mem_ack_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ack_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3300_0000 + i;
    end
    @(negedge clk); mem_rvalid_i = 1'b0; reset_i = 1'b1;
    @(negedge clk); reset_i = 1'b0; #1;
    n_checks++;
    if ({mem_req_o, refill_busy_o, fill_done_o, fill_we_o} !== 4'b0000 ||
        {fill_set_o, fill_tag_o, fill_word_o, mem_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_fill_outputs: got req=%b busy=%b done=%b we=%b set=%h tag=%h word=%0d addr=%h want all 0",
               mem_req_o, refill_busy_o, fill_done_o, fill_we_o, fill_set_o, fill_tag_o, fill_word_o, mem_addr_o);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3300_0002 + i; #1;
      n_checks++;
      if (fill_we_o !== 1'b0 || fill_done_o !== 1'b0) begin
        n_fail++; $display("FAIL rst_fill_late_beat%0d: got we=%b done=%b want 0 0", i, fill_we_o, fill_done_o);
      end
    end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_checks++;
    if (fill_done_o !== 1'b0 || refill_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_fill_no_done: got done=%b busy=%b want 0 0", fill_done_o, refill_busy_o);
    end
  endtask

  initial begin
    reset_i          = 1'b1;
    pc_f_i           = 32'h0000_1234;
    instr_hit_f_i    = 1'b0;
    ic_repl_permit_i = 1'b1;
    mem_ack_i        = 1'b0;
    mem_rvalid_i     = 1'b0;
    mem_rdata_i      = '0;
    test_reset();
    test_basic_miss();
    test_gapped();
    test_permit();
    test_back_to_back();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/icache_refill_ctlr.md
# icache_refill_ctlr

Miss-handling engine for the L1 instruction cache. It sits downstream of the instruction cache controller: it samples the fetch-stage hit flag and replacement permit, fetches the missing block from the next memory level as a burst of 32-bit beats, and streams the words into the cache data array. It then asserts a single-cycle tag/valid write. Fetch stalls on `refill_busy_o`.

## Interface
Parameters:
- `S`, 64, number of cache sets (power of two)
- `WORDS_PER_BLOCK`, 4, 32-bit words per block (power of two, ≥2)

Ports (clock and reset first):
- `clk_i`  in  1  system clock
- `reset_i`  in  1  reset; synchronous, active-high
- `pc_f_i`  in  32  fetch-stage PC
- `instr_hit_f_i`  in  1  fetch hit flag from the cache controller
- `ic_repl_permit_i`  in  1  replacement permitted this cycle
- `mem_req_o`  out  1  burst read request
- `mem_addr_o`  out  32  burst start address (word aligned)
- `mem_ack_i`  in  1  request accepted by memory
- `mem_rvalid_i`  in  1  read beat valid
- `mem_rdata_i`  in  32  read beat data
- `fill_we_o`  out  1  write one word into the data array
- `fill_set_o`  out  $clog2(S)  set being filled
- `fill_word_o`  out  $clog2(WORDS_PER_BLOCK)  word offset being written
- `fill_data_o`  out  32  word data
- `fill_tag_o`  out  32-$clog2(S)-$clog2(WORDS_PER_BLOCK)-2  tag of the block being filled
- `fill_done_o`  out  1  one-cycle pulse that writes the tag and sets the valid bit
- `refill_busy_o`  out  1  refill in progress; fetch stalls

## Operation
- **IDLE.** If `~instr_hit_f_i & ic_repl_permit_i`:
  - Latch the set, tag and word offset of `pc_f_i` into `blk_q`.
  - Go to REQ.
- **REQ.**
  - `mem_req_o=1`.
  - `mem_addr_o` = latched block base, plus the start offset (see Configuration).
  - Hold both until `mem_ack_i`, then go to FILL.
  - Reset the beat counter to 0 and load `word_q` with the start offset.
- **FILL.**
  - On each `mem_rvalid_i`: `fill_we_o=1` combinationally, `fill_data_o=mem_rdata_i`, `fill_word_o=word_q`.
  - After the write, `word_q` increments modulo `WORDS_PER_BLOCK` (wraps to 0).
  - The beat counter increments on each beat. On beat `WORDS_PER_BLOCK-1`, go to DONE.
- **DONE.** `fill_done_o=1` for exactly one cycle, with `fill_set_o`/`fill_tag_o` from `blk_q`. Go to IDLE.
- **Busy.** `refill_busy_o=1` in REQ, FILL and DONE.
- **Outputs in IDLE.** `fill_set_o`, `fill_tag_o` and `fill_word_o` show the `blk_q` values and are don't-care while their strobes are low.
- **No abort.** Once in REQ, the refill runs to completion. Deasserting `ic_repl_permit_i` or a redirect has no effect until IDLE.
- **Ignored inputs.**
  - `mem_rvalid_i` outside FILL, and `mem_ack_i` outside REQ.
  - `pc_f_i` changes after the latch in IDLE.
- **Reset.** All outputs 0; state IDLE; `blk_q`, `word_q` and the counter cleared. Reset mid-refill abandons the burst immediately, and late beats are then ignored.

## Timing
- Miss seen in IDLE at cycle N: `mem_req_o=1` at N+1.
- `mem_ack_i` at cycle A: FILL from A+1. A beat coincident with the ack is ignored.
- Beats may have gaps. Each valid beat writes in the same cycle it arrives (zero latency).
- Last beat at cycle L: `fill_done_o` at L+1. IDLE at L+2, where a new miss may be accepted. The earliest next `mem_req_o` is L+3.
- Minimum refill, from miss to `fill_done_o`: `WORDS_PER_BLOCK+2` cycles, with ack in the first REQ cycle and back-to-back beats.
- A miss is only sampled in IDLE. A miss during DONE is ignored but is re-detected in IDLE, because fetch is stalled.

## Configuration
- Macro: `ICACHE_CRITICAL_WORD_FIRST_EN`.
- **Defined:**
  - Start offset = latched word offset of `pc_f_i`, so `mem_addr_o` = block base + 4×offset.
  - Beats arrive wrapped: offset, offset+1, …, wrapping modulo `WORDS_PER_BLOCK`.
- **Undefined:**
  - Start offset = 0, so `mem_addr_o` = block base and beats arrive in words 0..`WORDS_PER_BLOCK-1`.
  - `word_q` never wraps.

## Structure
- Shared package `icache_pkg`:
  - `refill_state_t` enum: IDLE=2'b00, REQ=2'b01, FILL=2'b10, DONE=2'b11.
  - Tag, set and offset width localparams, derived from `S`/`WORDS_PER_BLOCK`.
- Sub-module `refill_beat_counter`:
  - Loadable modulo-`WORDS_PER_BLOCK` counter with a load value, an increment enable, and a `last_o` flag.
  - Instantiated for the beat count.
  - `word_q` is start offset + beat count, truncated.

## Test plan
- **Reset.** Reset asserted for 2 cycles → all outputs 0 and state IDLE. Held hit=0, permit=1 during reset → no `mem_req_o`.
- **Basic miss, macro undefined.**
  - Stimulus: PC=0x0000_1234 misses with permit=1, S=64, 4 words. Ack arrives 2 cycles after the request; beats D0..D3 arrive back-to-back.
  - Required: `mem_addr_o`=0x0000_1230; writes to set 0x23, words 0,1,2,3; `fill_tag_o`=0x4; one `fill_done_o` pulse one cycle after D3.
- **Critical word first, macro defined.** Same PC → `mem_addr_o`=0x0000_1234; `fill_word_o` sequence 1,2,3,0.
- **Gapped beats.** Beats with idle cycles between them, plus a spurious `mem_rvalid_i` during REQ → exactly 4 writes, none during REQ.
- **Permit gating.**
  - Miss with permit=0 → stays IDLE.
  - Permit dropped during FILL → refill completes; busy deasserts only after DONE.
- **Reset mid-FILL.** Reset after 2 beats → IDLE next cycle with outputs 0. The remaining 2 beats produce no `fill_we_o`.
